// File: rtl/cv32e40p_snn_fire.sv
// rtl/cv32e40p_snn_fire.sv - SNN fire/reset stage: row-serial threshold compare, spike map and reset write-back
module cv32e40p_snn_fire #(
    parameter int ROWS = 8,
    parameter int COLS = 16,
    parameter int DW   = 16,
    parameter int CW   = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_i,
    input  logic [DW-1:0]                       threshold_i,
    input  logic                                reset_mode_i,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0]   M_Cache_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [ROWS-1:0][COLS-1:0][DW-1:0]   M_Cache_o,
    output logic [ROWS-1:0][COLS-1:0]           spike_o,
    output logic [CW-1:0]                       spike_cnt_o
);

    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int RW = $clog2(ROWS + 1);
    localparam logic [DW:0]   MAX_WIDE = {2'b00, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MAX_POS  = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q;
    logic [AW-1:0]   row_idx;
    logic [DW-1:0]   thr_q;
    logic            mode_q;
    logic            row_active;

    logic [COLS-1:0][DW-1:0] cur_row;
    logic [COLS-1:0][DW-1:0] new_row;
    logic [COLS-1:0][DW:0]   diff;
    logic [COLS-1:0]         fire_row;
    logic [CW-1:0]           row_pop;

    assign row_idx    = row_q[AW-1:0];
    assign row_active = (row_q != RW'(ROWS));
    assign cur_row    = M_Cache_o[row_idx];
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);

    // Subtract-threshold result only saturates upward: a fired neuron has M >= thr.
    always_comb begin
        fire_row = '0;
        new_row  = cur_row;
        diff     = '0;
        row_pop  = '0;
        for (int c = 0; c < COLS; c++) begin
            fire_row[c] = ($signed(cur_row[c]) >= $signed(thr_q));
            diff[c]     = {cur_row[c][DW-1], cur_row[c]} - {thr_q[DW-1], thr_q};
            if (fire_row[c]) begin
                if (!mode_q) begin
                    new_row[c] = '0;
                end else if (diff[c] > MAX_WIDE) begin
                    new_row[c] = MAX_POS;
                end else begin
                    new_row[c] = diff[c][DW-1:0];
                end
            end
            row_pop = row_pop + CW'(fire_row[c]);
        end
    end

    // The row pointer runs one step past the last row so done_o lands on edge ROWS+1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SCAN;
            SCAN:    if (!row_active) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            thr_q       <= '0;
            mode_q      <= 1'b0;
            M_Cache_o   <= '0;
            spike_o     <= '0;
            spike_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        thr_q       <= threshold_i;
                        mode_q      <= reset_mode_i;
                        M_Cache_o   <= M_Cache_i;
                        spike_o     <= '0;
                        spike_cnt_o <= '0;
                        row_q       <= '0;
                    end
                end
                SCAN: begin
                    if (row_active) begin
                        M_Cache_o[row_idx] <= new_row;
                        spike_o[row_idx]   <= fire_row;
                        spike_cnt_o        <= spike_cnt_o + row_pop;
                        row_q              <= row_q + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_snn_fire.sv
// tb/tb_cv32e40p_snn_fire.sv - self-checking bench for cv32e40p_snn_fire
module tb_cv32e40p_snn_fire;

    localparam int ROWS = 8;
    localparam int COLS = 16;
    localparam int DW   = 16;
    localparam int CW   = 8;
    localparam int LAT  = ROWS + 1;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic                               start_i;
    logic [DW-1:0]                      threshold_i;
    logic                               reset_mode_i;
    logic [ROWS-1:0][COLS-1:0][DW-1:0]  M_Cache_i;
    logic                               busy_o;
    logic                               done_o;
    logic [ROWS-1:0][COLS-1:0][DW-1:0]  M_Cache_o;
    logic [ROWS-1:0][COLS-1:0]          spike_o;
    logic [CW-1:0]                      spike_cnt_o;

    cv32e40p_snn_fire #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .threshold_i  (threshold_i),
        .reset_mode_i (reset_mode_i),
        .M_Cache_i    (M_Cache_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .M_Cache_o    (M_Cache_o),
        .spike_o      (spike_o),
        .spike_cnt_o  (spike_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int thr;
        bit mode;
        int base;
        int r1, c1, v1;
        int r2, c2, v2;
        int e_base, e1, e2;
        bit s_base, s1, s2;
        int cnt;
    } vec_t;

    vec_t vecs[7];
    int   exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_inputs(input int i);
        threshold_i  = DW'(vecs[i].thr);
        reset_mode_i = vecs[i].mode;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                M_Cache_i[r][c] = DW'(vecs[i].base);
        M_Cache_i[vecs[i].r1][vecs[i].c1] = DW'(vecs[i].v1);
        M_Cache_i[vecs[i].r2][vecs[i].c2] = DW'(vecs[i].v2);
    endtask

    task automatic check_result(input string tag);
        int   i, nbad_m, nbad_s, ev, act;
        bit   es;
        i      = exp_q.pop_front();
        nbad_m = 0;
        nbad_s = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r == vecs[i].r1 && c == vecs[i].c1) begin
                    ev = vecs[i].e1; es = vecs[i].s1;
                end else if (r == vecs[i].r2 && c == vecs[i].c2) begin
                    ev = vecs[i].e2; es = vecs[i].s2;
                end else begin
                    ev = vecs[i].e_base; es = vecs[i].s_base;
                end
                act = int'($signed(M_Cache_o[r][c]));
                if (act != ev) nbad_m++;
                if (spike_o[r][c] != es) nbad_s++;
            end
        end
        chk({tag, "_cache_bad_cells"}, nbad_m, 0);
        chk({tag, "_spike_bad_cells"}, nbad_s, 0);
        chk({tag, "_spike_cnt"}, int'(spike_cnt_o), vecs[i].cnt);
    endtask

    // Starts vector i in the first IDLE cycle; optionally glitches start_i mid-scan
    // with vector glitch_vec's inputs, optionally aborts with reset after edge abort_at.
    task automatic run_pass(input int i, input string tag, input int glitch_vec, input int abort_at);
        int got;
        int w;
        w = 0;
        @(negedge clk);
        while (busy_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_idle_wait"}, int'(busy_o), 0);
        load_inputs(i);
        start_i = 1'b1;
        exp_q.push_back(i);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        got = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                void'(exp_q.pop_front());
                chk({tag, "_abort_busy"}, int'(busy_o), 0);
                chk({tag, "_abort_cnt"}, int'(spike_cnt_o), 0);
                chk({tag, "_abort_cache_nz"}, int'(M_Cache_o != '0), 0);
                chk({tag, "_abort_spike_nz"}, int'(spike_o != '0), 0);
                for (int h = 0; h < 3; h++) begin
                    @(posedge clk);
                    #1;
                    chk({tag, "_abort_done"}, int'(done_o), 0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (glitch_vec >= 0 && k == 3) begin
                load_inputs(glitch_vec);
                start_i = 1'b1;
            end
            if (k == 4) start_i = 1'b0;
            if (done_o) begin
                got = k;
                break;
            end
        end
        chk({tag, "_latency"}, got, LAT);
        chk({tag, "_busy_at_done"}, int'(busy_o), 1);
        if (got > 0) check_result(tag);
        else void'(exp_q.pop_front());
    endtask

    function automatic vec_t mk(int thr, bit mode, int base,
                                int r1, int c1, int v1, int r2, int c2, int v2,
                                int e_base, int e1, int e2,
                                bit s_base, bit s1, bit s2, int cnt);
        vec_t v;
        v.thr = thr; v.mode = mode; v.base = base;
        v.r1 = r1; v.c1 = c1; v.v1 = v1;
        v.r2 = r2; v.c2 = c2; v.v2 = v2;
        v.e_base = e_base; v.e1 = e1; v.e2 = e2;
        v.s_base = s_base; v.s1 = s1; v.s2 = s2;
        v.cnt = cnt;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(100, 0, 50,      3, 5, 100,     7, 15, 300,    50, 0, 0,          0, 1, 1, 2);
        vecs[1] = mk(100, 1, 0,       0, 0, 250,     2, 2, -5,      0, 150, -5,        0, 1, 0, 1);
        vecs[2] = mk(-32768, 1, 32767, 0, 0, 32767,  7, 15, 32767,  32767, 32767, 32767, 1, 1, 1, 128);
        vecs[3] = mk(-32768, 0, -32768, 1, 1, 0,     6, 6, 32767,   0, 0, 0,           1, 1, 1, 128);
        vecs[4] = mk(0, 1, -1,        4, 4, 0,       5, 9, 32767,   -1, 0, 32767,      0, 1, 1, 2);
        vecs[5] = mk(32767, 1, 32766, 1, 1, 32767,   6, 0, -32768,  32766, 0, -32768,  0, 1, 0, 1);
        vecs[6] = mk(-100, 1, -200,   2, 3, 50,      3, 3, -100,    -200, 150, 0,      0, 1, 1, 2);

        rst_n   = 1'b0;
        start_i = 1'b1;
        load_inputs(0);
        for (int h = 0; h < 4; h++) begin
            @(posedge clk);
            #1;
            chk("reset_done", int'(done_o), 0);
        end
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_cnt", int'(spike_cnt_o), 0);
        chk("reset_cache_nz", int'(M_Cache_o != '0), 0);
        chk("reset_spike_nz", int'(spike_o != '0), 0);
        @(negedge clk);
        start_i = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < 7; i++)
            run_pass(i, $sformatf("vec%0d", i), -1, 0);

        run_pass(0, "glitch", 1, 0);
        run_pass(1, "b2b", -1, 0);

        run_pass(2, "abort", -1, 4);
        run_pass(2, "post_abort", -1, 0);

        @(posedge clk);
        #1;
        chk("hold_cnt", int'(spike_cnt_o), 128);
        chk("hold_idle_busy", int'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
